// File: rtl/filter_ewma_mc.sv
// Multi-channel, multi-stage EWMA filter sharing one multiplier across all sections.
// Each accepted sample set is processed one section per cycle, then dout is published with a single out_valid pulse.
module filter_ewma_mc #(
  parameter int DATA_BITS = 12,
  parameter int CHANNELS  = 4,
  parameter int STAGES    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CHANNELS*DATA_BITS-1:0] din,
  input  logic [CHANNELS*9-1:0]         alpha,
  input  logic                          hp_mode,
  input  logic                          clr,
  output logic                          out_valid,
  output logic [CHANNELS*DATA_BITS-1:0] dout
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int ST_W = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int PW   = DATA_BITS + 10;

  localparam logic [CH_W-1:0] CH_LAST = CH_W'(CHANNELS - 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(STAGES - 1);
  localparam logic [CH_W-1:0] CH_ONE  = CH_W'(1);
  localparam logic [ST_W-1:0] ST_ONE  = ST_W'(1);
  localparam logic [CH_W-1:0] CH_ZERO = CH_W'(0);
  localparam logic [ST_W-1:0] ST_ZERO = ST_W'(0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Clamp a one-bit-wider signed value into the DATA_BITS signed range.
  function automatic logic signed [DATA_BITS-1:0] sat_fn(input logic signed [DATA_BITS:0] v);
    logic signed [DATA_BITS-1:0] r;
    if (v[DATA_BITS] != v[DATA_BITS-1]) begin
      if (v[DATA_BITS]) begin
        r = {1'b1, {(DATA_BITS-1){1'b0}}};
      end else begin
        r = {1'b0, {(DATA_BITS-1){1'b1}}};
      end
    end else begin
      r = v[DATA_BITS-1:0];
    end
    return r;
  endfunction

  state_t                         state_r;
  logic [CH_W-1:0]                ch_r;
  logic [ST_W-1:0]                stg_r;
  logic [CHANNELS*DATA_BITS-1:0]  din_r;
  logic [CHANNELS*9-1:0]          alpha_r;
  logic                           hp_r;
  logic                           in_ready_r;
  logic                           out_valid_r;
  logic signed [DATA_BITS-1:0]    st_r   [CHANNELS][STAGES];
  logic signed [DATA_BITS-1:0]    dout_r [CHANNELS];

  logic signed [DATA_BITS-1:0]    din_ch_s   [CHANNELS];
  logic [8:0]                     alpha_ch_s [CHANNELS];
  logic [ST_W-1:0]                prev_s;
  logic signed [DATA_BITS-1:0]    x_s;
  logic signed [DATA_BITS-1:0]    cur_s;
  logic [8:0]                     a_s;
  logic signed [DATA_BITS:0]      d_s;
  logic signed [PW-1:0]           d_ext_s;
  logic signed [PW-1:0]           a_ext_s;
  logic signed [PW-1:0]           prod_s;
  logic signed [DATA_BITS-1:0]    p_s;
  logic signed [DATA_BITS-1:0]    new_st_s;
  logic signed [DATA_BITS:0]      hp_s;
  logic signed [DATA_BITS-1:0]    out_s;

  // Unpack the latched sample set into per-channel views.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      din_ch_s[c]   = din_r[c*DATA_BITS +: DATA_BITS];
      alpha_ch_s[c] = alpha_r[c*9 +: 9];
    end
  end

  // Single shared section datapath for the section addressed by ch_r/stg_r.
  always_comb begin
    if (stg_r == ST_ZERO) begin
      prev_s = ST_ZERO;
    end else begin
      prev_s = stg_r - ST_ONE;
    end
    cur_s = st_r[ch_r][stg_r];
    if (stg_r == ST_ZERO) begin
      x_s = din_ch_s[ch_r];
    end else begin
      x_s = st_r[ch_r][prev_s];
    end
    // Any alpha at or above 256 means unity gain, so the section jumps straight to x.
    if (alpha_ch_s[ch_r][8]) begin
      a_s = 9'd256;
    end else begin
      a_s = alpha_ch_s[ch_r];
    end
    d_s      = {x_s[DATA_BITS-1], x_s} - {cur_s[DATA_BITS-1], cur_s};
    d_ext_s  = {{(PW-DATA_BITS-1){d_s[DATA_BITS]}}, d_s};
    a_ext_s  = {{(PW-9){1'b0}}, a_s};
    prod_s   = d_ext_s * a_ext_s;
    // The step lies between 0 and d, so the truncated sum cannot wrap.
    p_s      = DATA_BITS'(prod_s >>> 4'd8);
    new_st_s = cur_s + p_s;
    hp_s     = {din_ch_s[ch_r][DATA_BITS-1], din_ch_s[ch_r]} - {new_st_s[DATA_BITS-1], new_st_s};
    if (hp_r) begin
      out_s = sat_fn(hp_s);
    end else begin
      out_s = new_st_s;
    end
  end

  // Control FSM, input latches, filter state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      ch_r        <= CH_ZERO;
      stg_r       <= ST_ZERO;
      din_r       <= '0;
      alpha_r     <= '0;
      hp_r        <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        dout_r[c] <= '0;
        for (int s = 0; s < STAGES; s++) begin
          st_r[c][s] <= '0;
        end
      end
    end else begin
      out_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            din_r      <= din;
            alpha_r    <= alpha;
            hp_r       <= hp_mode;
            ch_r       <= CH_ZERO;
            stg_r      <= ST_ZERO;
            in_ready_r <= 1'b0;
            state_r    <= CALC;
            if (clr) begin
              for (int c = 0; c < CHANNELS; c++) begin
                for (int s = 0; s < STAGES; s++) begin
                  st_r[c][s] <= '0;
                end
              end
            end
          end
        end
        CALC: begin
          st_r[ch_r][stg_r] <= new_st_s;
          if (stg_r == ST_LAST) begin
            dout_r[ch_r] <= out_s;
            stg_r        <= ST_ZERO;
            if (ch_r == CH_LAST) begin
              ch_r        <= CH_ZERO;
              out_valid_r <= 1'b1;
              state_r     <= DONE;
            end else begin
              ch_r <= ch_r + CH_ONE;
            end
          end else begin
            stg_r <= stg_r + ST_ONE;
          end
        end
        DONE: begin
          in_ready_r <= 1'b1;
          state_r    <= IDLE;
        end
        default: begin
          in_ready_r <= 1'b1;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  // Pack per-channel results onto the output bus.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      dout[c*DATA_BITS +: DATA_BITS] = dout_r[c];
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_filter_ewma_mc.sv
// Directed bench for filter_ewma_mc: step response, rounding, pass-through,
// HP saturation, handshake, clr, per-channel alpha and mid-sample reset.
module tb_filter_ewma_mc;
  localparam int DB = 12;
  localparam int CH = 4;
  localparam int ST = 2;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic in_ready;
  logic [CH*DB-1:0] din;
  logic [CH*9-1:0] alpha;
  logic hp_mode;
  logic clr;
  logic out_valid;
  logic [CH*DB-1:0] dout;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  filter_ewma_mc #(.DATA_BITS(DB), .CHANNELS(CH), .STAGES(ST)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .din(din), .alpha(alpha), .hp_mode(hp_mode), .clr(clr),
    .out_valid(out_valid), .dout(dout)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_dout(input string tag, input int exp [CH]);
    for (int i = 0; i < CH; i++) begin
      chk($sformatf("%s.ch%0d", tag, i), $signed(dout[i*DB +: DB]), exp[i]);
    end
  endtask

  // One accept, latency check, output check, ready-again check.
  task automatic run(input string tag, input int d [CH], input int a [CH],
                     input logic hp, input logic c, input int exp [CH]);
    int lat;
    @(negedge clk);
    for (int i = 0; i < CH; i++) begin
      din[i*DB +: DB] = d[i][DB-1:0];
      alpha[i*9 +: 9] = a[i][8:0];
    end
    hp_mode  = hp;
    clr      = c;
    in_valid = 1'b1;
    chk({tag, ".rdy"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    clr      = 1'b0;
    din      = {$urandom, $urandom};
    alpha    = {$urandom, $urandom};
    hp_mode  = ~hp;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".lat"}, lat, 9);
    chk_dout(tag, exp);
    @(negedge clk);
    chk({tag, ".ovlow"}, out_valid, 0);
    chk({tag, ".rdy2"}, in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int npulse;
    int first;
    int last;
    int nov;
    rst = 1'b1; in_valid = 1'b0; din = '0; alpha = '0; hp_mode = 1'b0; clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.rdy", in_ready, 1);
    chk("rst.ov", out_valid, 0);
    chk_dout("rst.dout", '{0, 0, 0, 0});
    rst = 1'b0;

    run("step1", '{1024, 1024, 1024, 1024}, '{128, 128, 128, 128}, 1'b0, 1'b0, '{256, 256, 256, 256});
    run("step2", '{1024, 1024, 1024, 1024}, '{128, 128, 128, 128}, 1'b0, 1'b0, '{512, 512, 512, 512});
    run("step3", '{1024, 1024, 1024, 1024}, '{128, 128, 128, 128}, 1'b0, 1'b0, '{704, 704, 704, 704});
    run("step4", '{1024, 1024, 1024, 1024}, '{128, 128, 128, 128}, 1'b0, 1'b0, '{832, 832, 832, 832});

    run("round", '{-1, -1, -1, -1}, '{128, 128, 128, 128}, 1'b0, 1'b1, '{-1, -1, -1, -1});

    run("pass", '{100, -5, 2047, -2048}, '{256, 256, 256, 511}, 1'b0, 1'b0, '{100, -5, 2047, -2048});
    run("hpfree", '{0, 0, 0, 0}, '{0, 0, 0, 0}, 1'b1, 1'b0, '{-100, 5, -2047, 2047});

    run("load", '{2047, 2047, 2047, 2047}, '{256, 256, 256, 256}, 1'b0, 1'b1, '{2047, 2047, 2047, 2047});
    run("hpsat", '{-2048, -2048, -2048, -2048}, '{0, 0, 0, 0}, 1'b1, 1'b0, '{-2048, -2048, -2048, -2048});
    run("lphold", '{-2048, -2048, -2048, -2048}, '{0, 0, 0, 0}, 1'b0, 1'b0, '{2047, 2047, 2047, 2047});

    run("indep1", '{1000, -1000, 1000, 1000}, '{0, 64, 128, 256}, 1'b0, 1'b1, '{0, -63, 250, 1000});
    run("indep2", '{1000, -1000, 1000, 1000}, '{0, 64, 128, 256}, 1'b0, 1'b0, '{0, -157, 500, 1000});

    // Abort a sample mid-CALC with reset.
    @(negedge clk);
    din = {4{12'sd1024}}; alpha = {4{9'd128}}; hp_mode = 1'b0; clr = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst.rdy", in_ready, 1);
    chk("mrst.ov", out_valid, 0);
    chk_dout("mrst.dout", '{0, 0, 0, 0});
    @(negedge clk);
    rst = 1'b0;
    nov = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) nov++;
    end
    chk("mrst.noov", nov, 0);
    run("post", '{1024, 1024, 1024, 1024}, '{128, 128, 128, 128}, 1'b0, 1'b0, '{256, 256, 256, 256});

    // Hold in_valid continuously with clr and zero input.
    @(negedge clk);
    din = '0; alpha = {4{9'd128}}; hp_mode = 1'b0; clr = 1'b1; in_valid = 1'b1;
    npulse = 0; first = 0; last = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        npulse++;
        if (npulse == 1) first = i;
        last = i;
      end
    end
    in_valid = 1'b0; clr = 1'b0;
    chk("hs.pulses", npulse, 3);
    chk("hs.first", first, 9);
    chk("hs.last", last, 29);
    chk_dout("hs.clr", '{0, 0, 0, 0});
    repeat (12) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
